// File: rtl/four_bank_mem_responder.sv
// four_bank_mem_responder
//   Main-memory model behind the cache controller: four word-interleaved
//   banks of 16-bit words, one request per cycle, fixed two-cycle read
//   latency and per-bank occupancy reported combinationally as busy.
//
// Ports
//   clk       in   clock, all state on rising edge
//   rst       in   synchronous active-low reset
//   addr      in   16  byte address; [2:1] bank, [MEM_AW+2:3] row
//   data_in   in   16  write data
//   wr, rd    in   write / read request
//   data_out  out  16  read data, zero except in its valid cycle
//   busy      out  4   bank b cannot accept this cycle
//   err       out  request this cycle is illegal
//
// Build option
//   FOUR_BANK_MEM_ERR_EN : when defined, err reports illegal requests;
//   otherwise err is tied low and illegal requests are dropped silently.

module four_bank_mem_responder #(
    parameter int MEM_AW   = 13,
    parameter int BANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic [3:0]  busy,
    output logic        err
);

    localparam logic [3:0] CNT_LOAD = 4'(BANK_CYC - 1);

    logic [1:0]        bank;
    logic [MEM_AW-1:0] row;
    logic              req;
    logic              illegal;
    logic              acc;
    logic              unused_addr;

    assign bank = addr[2:1];
    assign row  = addr[MEM_AW+2:3];
    // Address bits above the row are intentionally ignored (addresses wrap).
    assign unused_addr = ^addr;

    assign req     = rd | wr;
    assign illegal = (rd & wr) | addr[0] | busy[bank];
    // Requests during reset are ignored, so acceptance is gated by rst.
    assign acc     = rst & req & ~illegal;

`ifdef FOUR_BANK_MEM_ERR_EN
    assign err = rst & req & illegal;
`else
    assign err = 1'b0;
`endif

    // Per-bank occupancy counter; busy follows the counter with no register.
    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [3:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (acc && (bank == 2'(b)))
                cnt_d = CNT_LOAD;
            else if (cnt_q != 4'd0)
                cnt_d = cnt_q - 4'd1;
        end

        always_ff @(posedge clk) begin
            if (!rst) cnt_q <= 4'd0;
            else      cnt_q <= cnt_d;
        end

        assign busy[b] = (cnt_q != 4'd0);
    end

    // Storage is never cleared by reset.
    logic [15:0] mem_q [4][2**MEM_AW];
    logic [15:0] rdata;

    always_ff @(posedge clk) begin
        if (acc && wr)
            mem_q[bank][row] <= data_in;
    end

    assign rdata = mem_q[bank][row];

    // Two-stage read pipeline; only the valid bits need reset.
    logic [2:1]  vld_pipe_q;
    logic [15:0] dat1_q, dat2_q;

    always_ff @(posedge clk) begin
        if (!rst) vld_pipe_q <= 2'b00;
        else      vld_pipe_q <= {vld_pipe_q[1], acc & rd};
    end

    always_ff @(posedge clk) begin
        dat1_q <= rdata;
        dat2_q <= dat1_q;
    end

    assign data_out = vld_pipe_q[2] ? dat2_q : 16'h0000;

endmodule

// File: tb/tb_four_bank_mem_responder.sv
module tb_four_bank_mem_responder;

    localparam int AW = 4;
    localparam int BC = 4;
`ifdef FOUR_BANK_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr = 1'b0, rd = 1'b0;
    logic [15:0] addr = 16'h0, data_in = 16'h0;
    logic [15:0] data_out;
    logic [3:0]  busy;
    logic        err;

    four_bank_mem_responder #(.MEM_AW(AW), .BANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .wr(wr), .rd(rd), .data_out(data_out), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: memory image, cycle at which each bank is free,
    // and read results scheduled by the cycle they must appear.
    int m_mem   [64];
    bit m_known [64];
    int m_free  [4];
    int m_pend  [int];

    initial begin
        for (int i = 0; i < 4; i++) m_free[i] = 0;
        for (int i = 0; i < 64; i++) begin m_mem[i] = 0; m_known[i] = 0; end
    end

    always @(negedge clk) begin : cmp
        int b, idx, c, ed;
        logic [3:0] eb;
        bit req, ill, acc;
        if (cyc >= 1) begin
            c = cyc;
            b = int'(addr[2:1]);
            for (int i = 0; i < 4; i++) eb[i] = (c < m_free[i]);
            req = rd || wr;
            ill = (rd && wr) || addr[0] || eb[b];
            acc = rst && req && !ill;
            ed  = m_pend.exists(c) ? m_pend[c] : 0;
            chk("busy", busy, eb);
            chk("err", err, ERR_EN && rst && req && ill);
            if (ed >= 0) chk("data_out", data_out, ed);
            m_pend.delete(c);
            if (!rst) begin
                m_pend.delete();
                for (int i = 0; i < 4; i++) m_free[i] = 0;
            end else if (acc) begin
                idx = int'(addr[6:1]);     // row*4 + bank for a 16-row bank
                if (wr) begin
                    m_mem[idx]   = int'(data_in);
                    m_known[idx] = 1'b1;
                end else begin
                    m_pend[c+2] = m_known[idx] ? m_mem[idx] : -1;
                end
                m_free[b] = c + BC;
            end
        end
    end

    task automatic drv(input bit r, input bit w, input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        rd = r; wr = w; addr = a; data_in = d;
    endtask
    task automatic idle(); drv(0, 0, 16'h0, 16'h0); endtask
    task automatic smp(); @(negedge clk); endtask

    logic [15:0] pre [64];
    logic [3:0]  bt  [8];
    logic [15:0] dt  [8];
    logic [15:0] ra;
    int          sel;

    initial begin
        bt = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        dt = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0};

        // reset
        repeat (3) @(posedge clk);
        smp();
        chk("rst_busy", busy, 4'b0000);
        chk("rst_data", data_out, 16'h0000);
        chk("rst_err", err, 1'b0);
        idle(); rst = 1'b1;

        // preload every row of every bank with nonzero data
        for (int k = 0; k < 64; k++) begin
            pre[k] = 16'($urandom_range(1, 16'hFFFF));
            drv(0, 1, 16'(k * 2), pre[k]);
        end
        repeat (4) idle();

        // write then read, latency two
        drv(0, 1, 16'h0000, 16'hA5A5);
        repeat (3) idle();
        drv(1, 0, 16'h0000, 16'h0); smp();
        idle(); smp(); chk("t1_lat1", data_out, 16'h0000);
        idle(); smp(); chk("t1_data", data_out, 16'hA5A5);
        idle(); smp(); chk("t1_lat3", data_out, 16'h0000);

        // four banks back to back
        repeat (3) idle();
        for (int i = 0; i < 4; i++) drv(0, 1, 16'(16'h10 + 2 * i), 16'(i + 1));
        repeat (4) idle();
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drv(1, 0, 16'(16'h10 + 2 * i), 16'h0);
            else       idle();
            smp();
            chk($sformatf("t2_busy%0d", i), busy, bt[i]);
            chk($sformatf("t2_data%0d", i), data_out, dt[i]);
            chk($sformatf("t2_err%0d", i), err, 1'b0);
        end

        // same-bank conflict and retry
        repeat (4) idle();
        drv(1, 0, 16'h0000, 16'h0); smp(); chk("t3_err0", err, 1'b0);
        drv(1, 0, 16'h0008, 16'h0); smp();
        chk("t3_busy0", busy[0], 1'b1);
        chk("t3_err1", err, ERR_EN);
        idle(); smp(); chk("t3_data", data_out, 16'hA5A5);
        idle(); smp(); chk("t3_nodata", data_out, 16'h0000);
        drv(1, 0, 16'h0008, 16'h0); smp();
        chk("t3_retry_err", err, 1'b0);
        idle(); idle(); smp(); chk("t3_retry_data", data_out, pre[4]);

        // illegal requests have no effect
        repeat (4) idle();
        drv(1, 1, 16'h0002, 16'hDEAD); smp(); chk("t4_rdwr_err", err, ERR_EN);
        idle(); smp(); chk("t4_rdwr_busy", busy, 4'b0000);
        drv(1, 0, 16'h0003, 16'h0); smp(); chk("t4_odd_err", err, ERR_EN);
        idle(); idle(); smp(); chk("t4_odd_nodata", data_out, 16'h0000);
        drv(1, 0, 16'h0002, 16'h0); idle(); idle(); smp();
        chk("t4_mem_kept", data_out, pre[1]);

        // reset while a read is in flight
        repeat (4) idle();
        drv(1, 0, 16'h0004, 16'h0); smp();
        idle(); rst = 1'b0; smp();
        chk("t5_data1", data_out, 16'h0000);
        chk("t5_err1", err, 1'b0);
        idle(); rst = 1'b1; smp();
        chk("t5_data2", data_out, 16'h0000);
        chk("t5_busy2", busy, 4'b0000);
        idle(); smp(); chk("t5_data3", data_out, 16'h0000);
        drv(1, 0, 16'h0004, 16'h0); idle(); idle(); smp();
        chk("t5_retained", data_out, pre[2]);

        // high address bits ignored: 0x4002 aliases 0x0002
        repeat (4) idle();
        drv(0, 1, 16'h4002, 16'h1234);
        repeat (4) idle();
        drv(1, 0, 16'h0002, 16'h0); idle(); idle(); smp();
        chk("t6_wrap", data_out, 16'h1234);

        // randomized traffic, checked by the model every cycle
        repeat (4) idle();
        repeat (3000) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 7) != 0) ra[0] = 1'b0;
            sel = $urandom_range(0, 9);
            if (sel <= 3)      drv(1, 0, ra, 16'($urandom));
            else if (sel <= 6) drv(0, 1, ra, 16'($urandom));
            else if (sel == 7) drv(1, 1, ra, 16'($urandom));
            else               idle();
            rst = ($urandom_range(0, 99) != 0);
        end
        idle(); rst = 1'b1;
        repeat (4) idle();
        smp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
